// File: rtl/booth_multiplier_param.sv
// Radix-2 Booth sequential multiplier, signed/unsigned per operation, optional early termination.
// Latency: N=X_WIDTH+1 iterations (fewer with early termination); done pulses the cycle after the last one.
// No backpressure: start is accepted only in IDLE or DONE and ignored while busy.
module booth_multiplier_param #(
    parameter int X_WIDTH    = 4,
    parameter int Y_WIDTH    = 6,
    parameter int EARLY_TERM = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       signed_mode,
    input  logic [X_WIDTH-1:0]         x_in,
    input  logic [Y_WIDTH-1:0]         y_in,
    output logic                       busy,
    output logic                       done,
    output logic [X_WIDTH+Y_WIDTH-1:0] result
);

    localparam int N  = X_WIDTH + 1;
    localparam int AW = Y_WIDTH + 2;
    localparam int MW = Y_WIDTH + 1;
    localparam int CW = $clog2(N + 1);
    localparam int SW = AW + N + 1;
    localparam int PW = X_WIDTH + Y_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   a_q, a_d;
    logic [N-1:0]    q_q, q_d;
    logic            q1_q, q1_d;
    logic [MW-1:0]   m_q, m_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   result_q, result_d;

    logic [AW-1:0]   m_ext;
    logic [AW-1:0]   a_sum;
    logic [SW-1:0]   shifted_one;
    logic [SW-1:0]   shifted_rem;
    logic [CW-1:0]   cnt_inc;
    logic [CW-1:0]   rem;
    logic            et_hit;

    always_comb begin
        m_ext = {m_q[MW-1], m_q};
        case ({q_q[0], q1_q})
            2'b01:   a_sum = a_q + m_ext;
            2'b10:   a_sum = a_q - m_ext;
            default: a_sum = a_q;
        endcase
        shifted_one = $signed({a_sum, q_q, q1_q}) >>> 1;
        cnt_inc     = cnt_q + 1'b1;
        rem         = CW'(N) - cnt_q;
        // Once Q is uniformly q_1, every remaining pair is 00/11: only shifts are left.
        shifted_rem = $signed({a_q, q_q, q1_q}) >>> rem;
        et_hit      = (EARLY_TERM != 0) && (q_q == {N{q1_q}});
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        q_d      = q_q;
        q1_d     = q1_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = '0;
                    q_d     = {signed_mode & x_in[X_WIDTH-1], x_in};
                    q1_d    = 1'b0;
                    m_d     = {signed_mode & y_in[Y_WIDTH-1], y_in};
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (et_hit) begin
                    {a_d, q_d, q1_d} = shifted_rem;
                    cnt_d   = CW'(N);
                    state_d = DONE;
                end else begin
                    {a_d, q_d, q1_d} = shifted_one;
                    cnt_d = cnt_inc;
                    if (cnt_inc == CW'(N)) begin
                        state_d = DONE;
                    end
                end
                if (state_d == DONE) begin
                    result_d = PW'({a_d, q_d});
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            q_q      <= '0;
            q1_q     <= 1'b0;
            m_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            q_q      <= q_d;
            q1_q     <= q1_d;
            m_q      <= m_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_booth_multiplier_param.sv
// Directed bench for booth_multiplier_param: fixed-latency, early-terminating and 8x8 instances.
module tb_booth_multiplier_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_f = 1'b0, start_e = 1'b0, start_w = 1'b0;
    logic        sm = 1'b0, sm_w = 1'b0;
    logic [3:0]  x4 = '0;
    logic [5:0]  y6 = '0;
    logic [7:0]  x8 = '0, y8 = '0;
    logic        busy_f, done_f, busy_e, done_e, busy_w, done_w;
    logic [9:0]  res_f, res_e;
    logic [15:0] res_w;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    booth_multiplier_param #(.X_WIDTH(4), .Y_WIDTH(6), .EARLY_TERM(0)) u_fix (
        .clk(clk), .rst(rst), .start(start_f), .signed_mode(sm), .x_in(x4), .y_in(y6),
        .busy(busy_f), .done(done_f), .result(res_f));

    booth_multiplier_param #(.X_WIDTH(4), .Y_WIDTH(6), .EARLY_TERM(1)) u_et (
        .clk(clk), .rst(rst), .start(start_e), .signed_mode(sm), .x_in(x4), .y_in(y6),
        .busy(busy_e), .done(done_e), .result(res_e));

    booth_multiplier_param #(.X_WIDTH(8), .Y_WIDTH(8), .EARLY_TERM(1)) u_w8 (
        .clk(clk), .rst(rst), .start(start_w), .signed_mode(sm_w), .x_in(x8), .y_in(y8),
        .busy(busy_w), .done(done_w), .result(res_w));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_busy(input int inst);
        return (inst == 0) ? busy_f : (inst == 1) ? busy_e : busy_w;
    endfunction

    function automatic logic get_done(input int inst);
        return (inst == 0) ? done_f : (inst == 1) ? done_e : done_w;
    endfunction

    function automatic logic [15:0] get_res(input int inst);
        return (inst == 0) ? {6'd0, res_f} : (inst == 1) ? {6'd0, res_e} : res_w;
    endfunction

    // Pulse start for one edge, then count edges until done (bounded).
    task automatic do_op(input int inst, input logic s, input logic [7:0] x, input logic [7:0] y,
                         output int lat, output int bcnt, output logic [15:0] res);
        logic seen;
        if (inst == 2) begin
            sm_w = s; x8 = x; y8 = y; start_w = 1'b1;
        end else begin
            sm = s; x4 = x[3:0]; y6 = y[5:0];
            if (inst == 0) start_f = 1'b1;
            else           start_e = 1'b1;
        end
        tick();
        start_f = 1'b0; start_e = 1'b0; start_w = 1'b0;
        bcnt = get_busy(inst) ? 1 : 0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            tick();
            lat++;
            if (get_done(inst)) seen = 1'b1;
            else if (get_busy(inst)) bcnt++;
        end
        res = get_res(inst);
        if (!seen) lat = 99;
    endtask

    initial begin
        int          lat, bcnt, dseen;
        logic [15:0] res;
        logic        seen;

        // Reset state
        #3;
        check("rst_busy", {31'd0, busy_f}, 32'd0);
        check("rst_done", {31'd0, done_f}, 32'd0);
        check("rst_result", {22'd0, res_f}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Fixed latency, unsigned 15 x 63
        do_op(0, 1'b0, 8'd15, 8'd63, lat, bcnt, res);
        check("fix_u_res", {16'd0, res}, 32'h3B1);
        check("fix_u_lat", lat, 5);
        check("fix_u_busy_cycles", bcnt, 5);
        check("fix_u_busy_at_done", {31'd0, busy_f}, 32'd0);
        tick();
        check("fix_u_done_pulse", {31'd0, done_f}, 32'd0);
        check("fix_u_res_hold", {22'd0, res_f}, 32'h3B1);

        // Fixed latency, signed -8 x -32 (most-negative multiplicand)
        do_op(0, 1'b1, 8'h08, 8'h20, lat, bcnt, res);
        check("fix_s_res", {16'd0, res}, 32'h100);
        check("fix_s_lat", lat, 5);

        // Early termination, signed -1 x 5
        do_op(1, 1'b1, 8'h0F, 8'd5, lat, bcnt, res);
        check("et_s_res", {16'd0, res}, 32'h3FB);
        check("et_s_lat", lat, 2);

        // Early termination, x = 0
        do_op(1, 1'b0, 8'd0, 8'd63, lat, bcnt, res);
        check("et_zero_res", {16'd0, res}, 32'h0);
        check("et_zero_lat", lat, 1);

        // Early termination, unsigned 15 x 63 still exact
        do_op(1, 1'b0, 8'd15, 8'd63, lat, bcnt, res);
        check("et_u_res", {16'd0, res}, 32'h3B1);

        // Reset in the middle of a run
        sm = 1'b0; x4 = 4'd15; y6 = 6'd63; start_f = 1'b1;
        tick();
        start_f = 1'b0;
        tick();
        tick();
        @(posedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, busy_f}, 32'd0);
        check("mid_rst_result", {22'd0, res_f}, 32'd0);
        dseen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done_f) dseen++;
        end
        rst = 1'b0;
        do_op(0, 1'b0, 8'd3, 8'd2, lat, bcnt, res);
        check("mid_rst_no_done", dseen, 0);
        check("post_rst_res", {16'd0, res}, 32'd6);
        check("post_rst_lat", lat, 5);

        // Back-to-back with start held high
        sm = 1'b0; x4 = 4'd2; y6 = 6'd3; start_f = 1'b1;
        tick();
        check("bb_busy0", {31'd0, busy_f}, 32'd1);
        lat = 0; seen = 1'b0;
        while (!seen && lat < 20) begin
            tick(); lat++; seen = done_f;
        end
        check("bb_lat1", lat, 5);
        check("bb_res1", {22'd0, res_f}, 32'd6);
        x4 = 4'd5; y6 = 6'd7;
        tick();
        check("bb_busy_next", {31'd0, busy_f}, 32'd1);
        check("bb_done_next", {31'd0, done_f}, 32'd0);
        check("bb_res_hold", {22'd0, res_f}, 32'd6);
        x4 = 4'd1; y6 = 6'd1;
        tick();
        tick();
        check("bb_run_ignore_busy", {31'd0, busy_f}, 32'd1);
        check("bb_run_ignore_done", {31'd0, done_f}, 32'd0);
        start_f = 1'b0;
        lat = 2; seen = 1'b0;
        while (!seen && lat < 20) begin
            tick(); lat++; seen = done_f;
        end
        check("bb_lat2", lat, 5);
        check("bb_res2", {22'd0, res_f}, 32'd35);
        tick();
        check("bb_idle_done", {31'd0, done_f}, 32'd0);
        check("bb_idle_busy", {31'd0, busy_f}, 32'd0);

        // 8x8 instance
        do_op(2, 1'b1, 8'h80, 8'h80, lat, bcnt, res);
        check("w8_s_res", {16'd0, res}, 32'h4000);
        check("w8_s_done_seen", {31'd0, lat != 99}, 32'd1);
        do_op(2, 1'b0, 8'hFF, 8'hFF, lat, bcnt, res);
        check("w8_u_res", {16'd0, res}, 32'hFE01);
        do_op(2, 1'b1, 8'hFF, 8'h80, lat, bcnt, res);
        check("w8_s_neg1_res", {16'd0, res}, 32'h0080);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/booth_multiplier_param.md
# booth_multiplier_param

Parametrised radix-2 Booth sequential multiplier, the next generation of the team's fixed 4x6 Booth unit. It generalises the operand widths and adds a per-operation signed/unsigned mode. It adds an optional early-termination path that collapses the remaining iterations into one barrel shift, plus a busy flag and back-to-back start acceptance. It sits behind the same start/done handshake as the existing multiplier and drops into the arithmetic datapath wherever a variable-latency multiply is acceptable.

## Interface
- X_WIDTH, 4, multiplier (x_in) width; must be ≥ 2
- Y_WIDTH, 6, multiplicand (y_in) width; must be ≥ 2
- EARLY_TERM, 1, 1 enables early termination; 0 gives fixed latency
- clk  in  1  rising-edge clock; single clock domain
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled on rising clk only in IDLE or DONE
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; captured with start
- x_in  in  X_WIDTH  multiplier; captured with start
- y_in  in  Y_WIDTH  multiplicand; captured with start
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse; result valid from this cycle
- result  out  X_WIDTH+Y_WIDTH  product; held until the next completion

## Operation
- Let N = X_WIDTH+1. Operands are extended internally by one bit: sign bit if signed_mode=1, zero if signed_mode=0.
  - M = extended y, width Y_WIDTH+1. Q = extended x, width N. q_1 = 0.
- Accumulator A is Y_WIDTH+2 bits and cleared at load. Extra headroom covers A−M with M most negative.
- States:
  - IDLE: start=1 → load A, Q, q_1, M and clear count; → RUN.
  - RUN, one iteration per cycle:
    - {Q[0],q_1}=01 → A+=M; 10 → A−=M; 00/11 → no add.
    - Then arithmetic shift right {A,Q,q_1} by 1; count++.
    - count reaching N → DONE.
  - DONE: result ← low X_WIDTH+Y_WIDTH bits of {A,Q} concatenation (product LSB = Q[0]); done=1.
    - start=1 → reload as in IDLE, → RUN (back-to-back).
    - Else → IDLE.
- Early termination (EARLY_TERM=1): at the start of a RUN cycle, check whether every bit of Q equals q_1.
  - If so, all remaining Booth pairs are 00 or 11. Arithmetic-shift {A,Q,q_1} right by r = N−count in that single cycle, then → DONE.
  - The check takes priority over the normal iteration.
- Required result:
  - signed_mode=1: result = x·y as two's complement, X_WIDTH+Y_WIDTH bits.
  - signed_mode=0: result = x·y unsigned. Exact in both modes; no overflow possible.
- start in RUN is ignored. Operands are not re-sampled, and busy and done are unaffected.
- Inputs are only required to be stable around the accepting edge.

## Timing
- Reset: state=IDLE, busy=0, done=0, result=0, A/Q/q_1/M/count=0. Asynchronous assertion takes effect immediately.
- Reset mid-RUN aborts the operation: no done pulse, result=0. First start is accepted on the first edge with rst low.
- Accepting edge E0: busy=1 from E0.
- EARLY_TERM=0: fixed latency. Iterations occur on edges E1..EN; done=1 and result valid for the cycle after EN; busy=0 in that cycle.
- EARLY_TERM=1: finishes on edge Ek, k ≤ N. done follows Ek, and k equals the number of iterations executed including the collapsing one.
  - x=0 always gives k=1.
- done is high exactly one cycle per completed operation. Back-to-back: start during the done cycle gives busy=1 the next cycle, with no IDLE cycle between.
- result updates only on the edge entering DONE; it is stable otherwise.

## Test plan
- Defaults, EARLY_TERM=0, unsigned, x=15, y=63 → result=945 (10'h3B1). done exactly 5 edges after acceptance; busy high for 5 cycles.
- Defaults, signed, x=4'b1000 (−8), y=6'b100000 (−32) → result=256 (10'h100). Covers most-negative M subtraction headroom.
- EARLY_TERM=1, signed, x=4'b1111 (−1), y=5 → result=10'h3FB (−5), done after edge 2. With x=0, y=63 → result=0, done after edge 1.
- Assert rst at edge 3 of a 15×63 run → done never pulses and result=0. A new start accepted after release (x=3, y=2) → result=6.
- Start held high continuously, x=2, y=3 then x=5, y=7 presented at the done cycle → two done pulses, result 6 then 35. Start during RUN ignored.
- X_WIDTH=8, Y_WIDTH=8, signed, −128×−128 → result=16'h4000; unsigned 255×255 → 16'hFE01.
